// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cacheline-to-burst adaptor.
// The optional CACHELINE_ADAPTOR_PERF_EN build adds performance counters to the top.
package cacheline_adaptor_pkg;

  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int ADDR_W     = 32;
  localparam int CL_BEATS   = LINE_W / BURST_W;
  localparam int CL_BURST_W = BURST_W;

  // A cacheline is 32 bytes, so the low five address bits are cleared for the burst.
  localparam logic [ADDR_W-1:0] CL_LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cl_adapt_state_t;

  function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] a);
    return a & CL_LINE_MASK;
  endfunction

  function automatic logic [7:0] beat_lo(input logic [1:0] c);
    return {c, 6'd0};
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Arbiter-side cacheline port and memory-side burst port of the adaptor.
// Upstream: read_i/write_i are held until the one-cycle resp_o pulse; memory: each cycle
// with read_o/write_o high and resp_i high transfers exactly one 64-bit beat.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cacheline read/write into a 4-beat 64-bit memory burst.
// Defining CACHELINE_ADAPTOR_PERF_EN adds read/write/stall performance counters.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus,
  output cl_adapt_state_t      dbg_state
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]          perf_rd_cnt,
  output logic [31:0]          perf_wr_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  cl_adapt_state_t   state_q;
  cl_adapt_state_t   state_d;
  logic [1:0]        cnt;
  logic [LINE_W-1:0] line_buf;
  logic [ADDR_W-1:0] addr_q;
  logic              last_beat;

  assign last_beat = bus.resp_i && (cnt == 2'(CL_BEATS - 1));
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.read_i)       state_d = RD;
        else if (bus.write_i) state_d = WR;
      end
      RD, WR:  if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt      <= 2'd0;
      line_buf <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.read_i) begin
            addr_q <= align_line(bus.address_i);
          end else if (bus.write_i) begin
            addr_q   <= align_line(bus.address_i);
            line_buf <= bus.line_i;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            line_buf[beat_lo(cnt) +: CL_BURST_W] <= bus.burst_i;
            cnt <= cnt + 2'd1;
          end
        end
        WR: begin
          if (bus.resp_i) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs come from registered state only, never from the request inputs.
  always_comb begin
    bus.read_o    = (state_q == RD);
    bus.write_o   = (state_q == WR);
    bus.resp_o    = (state_q == DONE);
    bus.address_o = (state_q == RD || state_q == WR) ? addr_q : '0;
    bus.burst_o   = (state_q == WR) ? line_buf[beat_lo(cnt) +: CL_BURST_W] : '0;
    bus.line_o    = line_buf;
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt    <= 32'd0;
      perf_wr_cnt    <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (state_q == RD && last_beat) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (state_q == WR && last_beat) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if ((state_q == RD || state_q == WR) && !bus.resp_i)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, writes with wait states, priority,
// mid-burst reset, spurious memory strobes, and the optional perf counters.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();
  cl_adapt_state_t dbg_state;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [LINE_W-1:0] exp_q[$];

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    total++;
    if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000 || bus.line_o !== '0 ||
        bus.burst_o !== '0 || bus.address_o !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset: ctl=%b line=%h burst=%h addr=%h st=%0d, want all zero st=0",
               {bus.resp_o, bus.read_o, bus.write_o}, bus.line_o, bus.burst_o,
               bus.address_o, dbg_state);
    end
  endtask

  task automatic test_read_b2b();
    logic [63:0] d[4];
    logic [LINE_W-1:0] exp;
    d[0] = {16{4'h1}}; d[1] = {16{4'h2}}; d[2] = {16{4'h3}}; d[3] = {16{4'h4}};
    exp_q.push_back({d[3], d[2], d[1], d[0]});
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    cyc();
    total++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b100 || bus.address_o !== 32'h0000_1220) begin
      bad++;
      $display("FAIL rd_start: ctl=%b addr=%h, want ctl=100 addr=00001220",
               {bus.read_o, bus.write_o, bus.resp_o}, bus.address_o);
    end
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = d[k];
      bus.resp_i  = 1'b1;
      cyc();
      if (k < 3) begin
        total++;
        if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b1) begin
          bad++;
          $display("FAIL rd_beat%0d: resp=%b read=%b, want resp=0 read=1", k, bus.resp_o, bus.read_o);
        end
      end
    end
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    bus.read_i  = 1'b0;
    exp = exp_q.pop_front();
    total++;
    if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0) begin
      bad++;
      $display("FAIL rd_resp_cycle5: resp=%b read=%b, want resp=1 read=0", bus.resp_o, bus.read_o);
    end
    total++;
    if (bus.line_o !== exp) begin
      bad++;
      $display("FAIL rd_line: got %h want %h", bus.line_o, exp);
    end
    cyc();
    total++;
    if (bus.resp_o !== 1'b0 || dbg_state !== IDLE || bus.line_o !== exp) begin
      bad++;
      $display("FAIL rd_hold: resp=%b st=%0d line=%h, want resp=0 st=0 line=%h",
               bus.resp_o, dbg_state, bus.line_o, exp);
    end
  endtask

  task automatic test_write_waits();
    logic [63:0] b[4];
    bit pat[6];
    int acc;
    int resp_seen;
    b[0] = 64'hDEAD_BEEF_0000_0123; b[1] = 64'hDEAD_BEEF_1111_0123;
    b[2] = 64'hDEAD_BEEF_2222_0123; b[3] = 64'hDEAD_BEEF_3333_0123;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 1;
    acc = 0;
    resp_seen = 0;
    bus.line_i    = {b[3], b[2], b[1], b[0]};
    bus.address_i = 32'h8000_0040;
    bus.write_i   = 1'b1;
    cyc();
    // Inputs changed mid-transaction must not leak into the burst.
    bus.line_i    = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    bus.address_i = 32'h1111_1111;
    total++;
    if ({bus.read_o, bus.write_o} !== 2'b01 || bus.address_o !== 32'h8000_0040 || bus.burst_o !== b[0]) begin
      bad++;
      $display("FAIL wr_start: rw=%b addr=%h burst=%h, want rw=01 addr=80000040 burst=%h",
               {bus.read_o, bus.write_o}, bus.address_o, bus.burst_o, b[0]);
    end
    for (int j = 0; j < 6; j++) begin
      bus.resp_i = pat[j];
      cyc();
      if (pat[j]) acc++;
      if (bus.resp_o === 1'b1) resp_seen++;
      if (acc == 4) bus.write_i = 1'b0;
      total++;
      if (acc < 4) begin
        if (bus.resp_o !== 1'b0 || bus.write_o !== 1'b1 || bus.burst_o !== b[acc] ||
            bus.address_o !== 32'h8000_0040) begin
          bad++;
          $display("FAIL wr_step%0d: resp=%b wr=%b burst=%h addr=%h, want resp=0 wr=1 burst=%h addr=80000040",
                   j, bus.resp_o, bus.write_o, bus.burst_o, bus.address_o, b[acc]);
        end
      end else if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin
        bad++;
        $display("FAIL wr_done: resp=%b wr=%b, want resp=1 wr=0", bus.resp_o, bus.write_o);
      end
    end
    bus.resp_i = 1'b0;
    cyc();
    if (bus.resp_o === 1'b1) resp_seen++;
    total++;
    if (resp_seen !== 1 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL wr_resp_once: pulses=%0d st=%0d, want pulses=1 st=0", resp_seen, dbg_state);
    end
    clear_inputs();
  endtask

  task automatic test_both_req();
    logic [63:0] d[4];
    logic [LINE_W-1:0] exp;
    int wr_seen;
    wr_seen = 0;
    for (int k = 0; k < 4; k++) d[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
    exp = {d[3], d[2], d[1], d[0]};
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    bus.line_i    = {4{64'hFFFF_0000_FFFF_0000}};
    bus.address_i = 32'h0000_0045;
    cyc();
    if (bus.write_o === 1'b1) wr_seen++;
    total++;
    if (bus.read_o !== 1'b1 || bus.address_o !== 32'h0000_0040) begin
      bad++;
      $display("FAIL both_prio: read=%b addr=%h, want read=1 addr=00000040", bus.read_o, bus.address_o);
    end
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = d[k];
      bus.resp_i  = 1'b1;
      cyc();
      if (bus.write_o === 1'b1) wr_seen++;
    end
    clear_inputs();
    total++;
    if (bus.resp_o !== 1'b1 || bus.line_o !== exp || wr_seen !== 0) begin
      bad++;
      $display("FAIL both_done: resp=%b line=%h wr_cycles=%0d, want resp=1 line=%h wr_cycles=0",
               bus.resp_o, bus.line_o, wr_seen, exp);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d[4];
    logic [LINE_W-1:0] exp;
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0100;
    cyc();
    for (int k = 0; k < 2; k++) begin
      bus.burst_i = 64'hEEEE_EEEE_0000_0000 + 64'(k);
      bus.resp_i  = 1'b1;
      cyc();
    end
    clear_inputs();
    rst = 1'b1;
    cyc();
    total++;
    if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000 || bus.line_o !== '0 ||
        bus.burst_o !== '0 || bus.address_o !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL rst_mid: ctl=%b line=%h burst=%h addr=%h st=%0d, want all zero st=0",
               {bus.resp_o, bus.read_o, bus.write_o}, bus.line_o, bus.burst_o,
               bus.address_o, dbg_state);
    end
    rst = 1'b0;
    cyc();
    total++;
    if (bus.resp_o !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL rst_no_resp: resp=%b st=%0d, want resp=0 st=0", bus.resp_o, dbg_state);
    end
    d[0] = 64'h0123_4567_89AB_CDEF; d[1] = 64'hFEDC_BA98_7654_3210;
    d[2] = 64'h0F0F_0F0F_F0F0_F0F0; d[3] = 64'h5555_AAAA_5555_AAAA;
    exp_q.push_back({d[3], d[2], d[1], d[0]});
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_021F;
    cyc();
    total++;
    if (bus.address_o !== 32'h0000_0200 || bus.read_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_reread_addr: read=%b addr=%h, want read=1 addr=00000200", bus.read_o, bus.address_o);
    end
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = d[k];
      bus.resp_i  = 1'b1;
      cyc();
    end
    clear_inputs();
    exp = exp_q.pop_front();
    total++;
    if (bus.resp_o !== 1'b1 || bus.line_o !== exp) begin
      bad++;
      $display("FAIL rst_reread_line: resp=%b line=%h, want resp=1 line=%h", bus.resp_o, bus.line_o, exp);
    end
    cyc();
  endtask

  task automatic test_spurious();
    logic [LINE_W-1:0] prev;
    logic [63:0] d[4];
    logic [LINE_W-1:0] exp;
    prev = {64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0,
            64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hBADB_ADBA_DBAD_BADB;
    for (int k = 0; k < 3; k++) cyc();
    total++;
    if (dbg_state !== IDLE || bus.line_o !== prev || {bus.read_o, bus.write_o, bus.resp_o} !== 3'b000) begin
      bad++;
      $display("FAIL spur_idle: st=%0d ctl=%b line=%h, want st=0 ctl=000 line=%h",
               dbg_state, {bus.read_o, bus.write_o, bus.resp_o}, bus.line_o, prev);
    end
    for (int k = 0; k < 4; k++) d[k] = 64'hC0DE_0000_0000_0000 | (64'(k + 1) << 8);
    exp = {d[3], d[2], d[1], d[0]};
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0300;
    cyc();
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = d[k];
      cyc();
    end
    bus.read_i  = 1'b0;
    bus.burst_i = 64'hBADB_ADBA_DBAD_BADB;
    total++;
    if (bus.resp_o !== 1'b1 || bus.line_o !== exp) begin
      bad++;
      $display("FAIL spur_rd_done: resp=%b line=%h, want resp=1 line=%h", bus.resp_o, bus.line_o, exp);
    end
    cyc();
    cyc();
    total++;
    if (dbg_state !== IDLE || bus.resp_o !== 1'b0 || bus.line_o !== exp) begin
      bad++;
      $display("FAIL spur_done: st=%0d resp=%b line=%h, want st=0 resp=0 line=%h",
               dbg_state, bus.resp_o, bus.line_o, exp);
    end
    clear_inputs();
  endtask

`ifdef CACHELINE_ADAPTOR_PERF_EN
  task automatic run_txn(input bit wr, input logic [31:0] a, input int stalls);
    bus.read_i    = !wr;
    bus.write_i   = wr;
    bus.address_i = a;
    bus.line_i    = {8{a}};
    cyc();
    bus.resp_i = 1'b0;
    for (int s = 0; s < stalls; s++) cyc();
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = {a, 32'(k)};
      bus.resp_i  = 1'b1;
      cyc();
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_perf();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (perf_rd_cnt !== 32'd0 || perf_wr_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_reset: rd=%0d wr=%0d stall=%0d, want 0 0 0", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
    run_txn(1'b0, 32'h0000_1000, 1);
    run_txn(1'b1, 32'h0000_2000, 0);
    run_txn(1'b0, 32'h0000_3000, 0);
    run_txn(1'b1, 32'h0000_4000, 2);
    run_txn(1'b0, 32'h0000_5000, 2);
    total++;
    if (perf_rd_cnt !== 32'd3 || perf_wr_cnt !== 32'd2 || perf_stall_cnt !== 32'd5) begin
      bad++;
      $display("FAIL perf_counts: rd=%0d wr=%0d stall=%0d, want 3 2 5", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_b2b();
    test_write_waits();
    test_both_req();
    test_reset_mid();
    test_spurious();
`ifdef CACHELINE_ADAPTOR_PERF_EN
    test_perf();
`endif
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
